// File: rtl/bcd_sw_pkg.sv
// Shared types and helpers for the BCD stopwatch controller and its digit cells.
package bcd_sw_pkg;

    localparam int         DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef logic [1:0] sw_state_t;

    localparam sw_state_t ST_IDLE  = 2'd0;
    localparam sw_state_t ST_RUN   = 2'd1;
    localparam sw_state_t ST_PAUSE = 2'd2;

    // Values above 9 can only come from upsets; they fold back to 0 on the next increment.
    function automatic logic [DIGIT_W-1:0] bcd_next(input logic [DIGIT_W-1:0] q,
                                                    input logic               inc);
        if (!inc)
            return q;
        return (q >= BCD_MAX) ? '0 : q + DIGIT_W'(1);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the stopwatch count chain; carry feeds the next digit's inc.
module bcd_digit
    import bcd_sw_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               inc,
    output logic [DIGIT_W-1:0] q,
    output logic               carry
);

    always_ff @(posedge clk) begin
        if (reset || clr)
            q <= '0;
        else
            q <= bcd_next(q, inc);
    end

    assign carry = inc && (q == BCD_MAX);

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Stopwatch controller: RUN/PAUSE/IDLE FSM, tick prescaler, BCD digit chain, display mux.
// Optional lap hold is built when STOPWATCH_LAP_EN is defined.
module bcd_stopwatch_ctrl
    import bcd_sw_pkg::*;
#(
    parameter int TICK_DIV = 100000,
    parameter int DIGITS   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_stop,
    input  logic                clear,
    input  logic                lap,
    output logic [4*DIGITS-1:0] count,
    output logic [4*DIGITS-1:0] disp,
    output logic                running,
    output logic                rollover,
    output logic [1:0]          state
);

    localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    sw_state_t                         state_nxt;
    logic [PW-1:0]                     presc;
    logic                              in_run;
    logic                              clr_cmd;
    logic                              tick;
    logic [DIGITS:0]                   inc;
    logic [DIGITS-1:0][DIGIT_W-1:0]    digit_q;
    logic [DIGITS-1:0][DIGIT_W-1:0]    digit_nxt;
    logic [4*DIGITS-1:0]               count_nxt;

    assign in_run  = (state == ST_RUN);
    assign clr_cmd = clear && ((state == ST_IDLE) || (state == ST_PAUSE));
    assign tick    = in_run && (presc == PRESC_LAST);
    assign inc[0]  = tick;
    assign running = in_run;

    // clear outranks start_stop only outside RUN; in RUN clear is ignored.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (clear) state_nxt = ST_IDLE;
                      else if (start_stop) state_nxt = ST_RUN;
            ST_RUN:   if (start_stop) state_nxt = ST_PAUSE;
            ST_PAUSE: if (clear) state_nxt = ST_IDLE;
                      else if (start_stop) state_nxt = ST_RUN;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Holds its value outside RUN so a pause keeps the partial period.
    always_ff @(posedge clk) begin
        if (reset || clr_cmd)
            presc <= '0;
        else if (in_run)
            presc <= tick ? '0 : presc + PW'(1);
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk   (clk),
            .reset (reset),
            .clr   (clr_cmd),
            .inc   (inc[g]),
            .q     (digit_q[g]),
            .carry (inc[g+1])
        );
        assign digit_nxt[g] = clr_cmd ? '0 : bcd_next(digit_q[g], inc[g]);
    end

    assign count     = digit_q;
    assign count_nxt = digit_nxt;

    // Carry out of the top digit is exactly the all-9 wrap on a tick.
    always_ff @(posedge clk) begin
        if (reset)
            rollover <= 1'b0;
        else
            rollover <= inc[DIGITS];
    end

`ifdef STOPWATCH_LAP_EN
    logic                hold;
    logic                hold_nxt;
    logic [4*DIGITS-1:0] lap_reg;
    logic [4*DIGITS-1:0] lap_nxt;

    always_comb begin
        hold_nxt = hold;
        lap_nxt  = lap_reg;
        if (clr_cmd) begin
            hold_nxt = 1'b0;
        end else if (lap) begin
            if (hold) begin
                hold_nxt = 1'b0;
            end else if (in_run) begin
                hold_nxt = 1'b1;
                lap_nxt  = count;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold    <= 1'b0;
            lap_reg <= '0;
            disp    <= '0;
        end else begin
            hold    <= hold_nxt;
            lap_reg <= lap_nxt;
            disp    <= hold_nxt ? lap_nxt : count_nxt;
        end
    end
`else
    logic unused_lap;
    assign unused_lap = lap;

    // Registered from the next-count value so disp tracks count cycle for cycle.
    always_ff @(posedge clk) begin
        if (reset)
            disp <= '0;
        else
            disp <= count_nxt;
    end
`endif

endmodule
